uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Parallel-side peer of the UART block. Consumes received bytes (rx_p_data/rx_d_valid) and parses them as register-access command frames against an internal 2^ADDR_W x 8 register file.
- Returns read data through the UART transmitter's parallel input (tx_p_data/tx_d_valid), honouring tx_busy.
- Register 0 is exported as a configuration byte.

Parameters:
- ADDR_W, 4, register file address width; depth = 2^ADDR_W.
- WR_CMD, 8'hAA, opcode for a write frame.
- RD_CMD, 8'hBB, opcode for a read frame.
- TIMEOUT_CYC, 16'd5000, inter-byte timeout in clk cycles; used only with FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rest  in  1  synchronous reset, active-high.
- rx_p_data  in  8  received byte from the UART receiver.
- rx_d_valid  in  1  one-cycle strobe, rx_p_data valid.
- tx_p_data  out  8  byte to the UART transmitter.
- tx_d_valid  out  1  one-cycle strobe to the UART transmitter.
- tx_busy  in  1  UART transmitter busy.
- cfg0  out  8  continuous copy of reg[0].
- ill_cmd  out  1  one-cycle pulse when an unknown opcode is received in IDLE.
- overrun  out  1  sticky flag: a byte was dropped while the responder was transmitting.

Behaviour:
- Reset (rest=1 at clk edge):
  - state=IDLE; all registers 0.
  - tx_p_data=0, tx_d_valid=0, cfg0=0, ill_cmd=0, overrun=0.
  - Reset mid-frame or mid-transmit aborts immediately; no further tx_d_valid is issued.
- Frames:
  - Write: WR_CMD, addr, data.
  - Read: RD_CMD, addr. Response is one byte, reg[addr].
  - Only addr[ADDR_W-1:0] is used; upper address bits are ignored.
- All outputs are registered. ill_cmd and tx_d_valid are high for exactly one cycle per event.
- FSM states and transitions:
  - IDLE:
    - rx_d_valid with WR_CMD -> WR_ADDR.
    - rx_d_valid with RD_CMD -> RD_ADDR.
    - Any other byte: ill_cmd=1 next cycle; stay in IDLE.
  - WR_ADDR: on rx_d_valid, latch addr -> WR_DATA.
  - WR_DATA: on rx_d_valid, reg[addr]<=rx_p_data -> IDLE.
    - cfg0 reflects a write to addr 0 one cycle after the data strobe.
    - No response byte is sent for writes.
  - RD_ADDR: on rx_d_valid, tx_p_data<=reg[rx_p_data[ADDR_W-1:0]] -> TX_SEND.
  - TX_SEND: when tx_busy==0, tx_d_valid<=1 -> TX_WAIT_HI. While tx_busy==1, hold.
  - TX_WAIT_HI: wait for tx_busy==1 -> TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_busy==0 -> IDLE.
- Latency: address strobe at cycle n -> tx_d_valid high at cycle n+2 at the earliest (tx_busy low).
- tx_p_data holds its value from TX_SEND until the next read loads it.
- Bytes arriving during TX_SEND/TX_WAIT_HI/TX_WAIT_LO are dropped and overrun<=1. overrun clears only on reset.
- Opcode values inside WR_ADDR/WR_DATA/RD_ADDR are treated as plain data, not commands.
- rx_d_valid is sampled only in the cycle it is high; back-to-back strobes in consecutive cycles are each consumed.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every rx_d_valid and on entry to WR_ADDR or RD_ADDR.
  - It increments every cycle while in WR_ADDR, WR_DATA or RD_ADDR.
  - On reaching TIMEOUT_CYC-1 without a strobe: FSM -> IDLE and the partial frame is discarded. No register write, no tx_d_valid.
  - A strobe arriving in the same cycle as the timeout wins: the byte is consumed and no timeout occurs.
- Not defined: no counter; the FSM waits indefinitely for the next frame byte.

Test Plan:
- Write then read back: send AA,03,5C then BB,03 with tx_busy low.
  - tx_d_valid pulses once with tx_p_data=8'h5C, two cycles after the 03 strobe.
  - Then model tx_busy high 10 cycles, low; FSM returns to IDLE.
- Config export: send AA,10,C3 (ADDR_W=4, so addr 0).
  - cfg0=8'hC3 one cycle after the C3 strobe; reading BB,00 returns C3.
- Illegal opcode: send 7E in IDLE.
  - ill_cmd high for one cycle; following BB,00 after reset returns 00.
- Busy stall and overrun:
  - Hold tx_busy=1 before BB,02; tx_d_valid stays low until tx_busy drops, then pulses once.
  - A byte injected during TX_WAIT_LO sets overrun=1 and is otherwise ignored.
- Reset mid-frame: send AA,05 then assert rest for one cycle, then send 11.
  - reg[5] stays 0; 11 is treated as an opcode, so ill_cmd pulses.
- Timeout (FRAME_TIMEOUT_EN, TIMEOUT_CYC=20): send BB, wait 25 cycles, send AA,01,22.
  - No tx_d_valid occurs; reg[1]=22 on readback.

Source files
------------

// File: rtl/uart_cmd_responder_if.sv
// Byte-stream bundle between the UART block and its command responder.
// master drives received bytes and tx_busy; slave returns transmit bytes.
interface uart_cmd_responder_if;
    logic [7:0] rx_p_data;
    logic       rx_d_valid;
    logic [7:0] tx_p_data;
    logic       tx_d_valid;
    logic       tx_busy;

    modport master (
        output rx_p_data, rx_d_valid, tx_busy,
        input  tx_p_data, tx_d_valid
    );

    modport slave (
        input  rx_p_data, rx_d_valid, tx_busy,
        output tx_p_data, tx_d_valid
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Parses received bytes as register write/read frames and returns read data to the UART transmitter.
// Optional inter-byte frame timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_cmd_responder #(
    parameter int unsigned ADDR_W      = 4,
    parameter logic [7:0]  WR_CMD      = 8'hAA,
    parameter logic [7:0]  RD_CMD      = 8'hBB,
    parameter logic [15:0] TIMEOUT_CYC = 16'd5000
) (
    input  logic                 clk,
    input  logic                 rest,
    uart_cmd_responder_if.slave  bus,
    output logic [7:0]           cfg0,
    output logic                 ill_cmd,
    output logic                 overrun
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        TX_SEND,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        regs [DEPTH];
    logic              frame_timeout;
    logic              addr_we, reg_we, tx_load, tx_fire, ill_next, drop;

    assign cfg0 = regs[0];

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        in_frame;

    assign in_frame = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);

    // Held at zero outside a frame, so entry into WR_ADDR/RD_ADDR starts from zero.
    always_ff @(posedge clk) begin
        if (rest || bus.rx_d_valid || !in_frame)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 16'd1;
    end

    assign frame_timeout = in_frame && !bus.rx_d_valid && (to_cnt == TIMEOUT_CYC - 16'd1);
`else
    // Without the counter a frame never expires; TIMEOUT_CYC is inert here.
    assign frame_timeout = 1'b0 & (TIMEOUT_CYC != '0);
`endif

    always_ff @(posedge clk) begin
        if (rest)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_we    = 1'b0;
        reg_we     = 1'b0;
        tx_load    = 1'b0;
        tx_fire    = 1'b0;
        ill_next   = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_d_valid) begin
                    if (bus.rx_p_data == WR_CMD)
                        state_next = WR_ADDR;
                    else if (bus.rx_p_data == RD_CMD)
                        state_next = RD_ADDR;
                    else
                        ill_next = 1'b1;
                end
            end
            WR_ADDR: begin
                if (bus.rx_d_valid) begin
                    addr_we    = 1'b1;
                    state_next = WR_DATA;
                end else if (frame_timeout) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                if (bus.rx_d_valid) begin
                    reg_we     = 1'b1;
                    state_next = IDLE;
                end else if (frame_timeout) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.rx_d_valid) begin
                    tx_load    = 1'b1;
                    state_next = TX_SEND;
                end else if (frame_timeout) begin
                    state_next = IDLE;
                end
            end
            TX_SEND: begin
                drop = bus.rx_d_valid;
                if (!bus.tx_busy) begin
                    tx_fire    = 1'b1;
                    state_next = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                drop = bus.rx_d_valid;
                if (bus.tx_busy)
                    state_next = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                drop = bus.rx_d_valid;
                if (!bus.tx_busy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            addr_q         <= '0;
            bus.tx_p_data  <= '0;
            bus.tx_d_valid <= 1'b0;
            ill_cmd        <= 1'b0;
            overrun        <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            bus.tx_d_valid <= tx_fire;
            ill_cmd        <= ill_next;
            if (drop)
                overrun <= 1'b1;
            if (addr_we)
                addr_q <= bus.rx_p_data[ADDR_W-1:0];
            if (tx_load)
                bus.tx_p_data <= regs[bus.rx_p_data[ADDR_W-1:0]];
            if (reg_we)
                regs[addr_q] <= bus.rx_p_data;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed plan steps followed by randomized frames.
// Checked against a plain array model of the register file; timeout steps need FRAME_TIMEOUT_EN.
module tb_uart_cmd_responder;

    localparam logic [7:0] WR = 8'hAA;
    localparam logic [7:0] RD = 8'hBB;

    logic       clk = 1'b0;
    logic       rest;
    logic [7:0] cfg0;
    logic       ill_cmd;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] model [16];
    logic       model_ovr;

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(
        .ADDR_W      (4),
        .WR_CMD      (8'hAA),
        .RD_CMD      (8'hBB),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .clk     (clk),
        .rest    (rest),
        .bus     (bus.slave),
        .cfg0    (cfg0),
        .ill_cmd (ill_cmd),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        model_ovr = 1'b0;
    endtask

    // Strobe one byte; returns 1 time unit after the capturing edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_p_data  = b;
        bus.rx_d_valid = 1'b1;
        tick();
        bus.rx_d_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(WR);
        chk("wr_no_ill", {7'd0, ill_cmd}, 8'd0);
        send_byte(a);
        send_byte(d);
        model[a[3:0]] = d;
        chk("cfg0_after_wr", cfg0, model[0]);
    endtask

    task automatic do_illegal(input logic [7:0] b);
        send_byte(b);
        chk("ill_pulse", {7'd0, ill_cmd}, 8'd1);
        tick();
        chk("ill_clear", {7'd0, ill_cmd}, 8'd0);
    endtask

    // Read frame with optional pre-stall (tx_busy held high), UART busy window, and an injected byte.
    task automatic do_read(input logic [7:0] a, input int stall, input int busy_len, input bit inject);
        logic [7:0] exp;
        exp = model[a[3:0]];
        bus.tx_busy = (stall > 0);
        send_byte(RD);
        send_byte(a);
        chk("rd_lat_n1", {7'd0, bus.tx_d_valid}, 8'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rd_stall_low", {7'd0, bus.tx_d_valid}, 8'd0);
        end
        bus.tx_busy = 1'b0;
        tick();
        chk("rd_valid_hi", {7'd0, bus.tx_d_valid}, 8'd1);
        chk("rd_data", bus.tx_p_data, exp);
        tick();
        chk("rd_valid_one", {7'd0, bus.tx_d_valid}, 8'd0);
        bus.tx_busy = 1'b1;
        tick();
        for (int i = 1; i < busy_len; i++) begin
            if (inject && i == 1) begin
                bus.rx_p_data  = WR;
                bus.rx_d_valid = 1'b1;
                tick();
                bus.rx_d_valid = 1'b0;
                model_ovr = 1'b1;
            end else begin
                tick();
            end
            chk("busy_no_valid", {7'd0, bus.tx_d_valid}, 8'd0);
        end
        bus.tx_busy = 1'b0;
        tick();
        chk("overrun", {7'd0, overrun}, {7'd0, model_ovr});
        chk("tx_hold", bus.tx_p_data, exp);
    endtask

    initial begin
        int pulses;
        rest           = 1'b1;
        bus.rx_p_data  = 8'h00;
        bus.rx_d_valid = 1'b0;
        bus.tx_busy    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_tx_data", bus.tx_p_data, 8'h00);
        chk("rst_tx_valid", {7'd0, bus.tx_d_valid}, 8'd0);
        chk("rst_cfg0", cfg0, 8'h00);
        chk("rst_ill", {7'd0, ill_cmd}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        rest = 1'b0;
        tick();

        do_read(8'h00, 0, 3, 1'b0);
        do_write(8'h03, 8'h5C);
        do_read(8'h03, 0, 10, 1'b0);

        do_write(8'h10, 8'hC3);
        chk("cfg0_export", cfg0, 8'hC3);
        do_read(8'h00, 0, 4, 1'b0);

        do_illegal(8'h7E);

        do_read(8'h02, 5, 6, 1'b1);
        do_write(8'h02, 8'h9D);
        do_read(8'h12, 0, 2, 1'b0);

        send_byte(WR);
        send_byte(8'h05);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        model_reset();
        chk("midrst_cfg0", cfg0, 8'h00);
        chk("midrst_ovr", {7'd0, overrun}, 8'd0);
        do_illegal(8'h11);
        do_read(8'h05, 0, 2, 1'b0);

`ifdef FRAME_TIMEOUT_EN
        send_byte(RD);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.tx_d_valid) pulses++;
        end
        chk("timeout_no_tx", pulses[7:0], 8'd0);
        do_write(8'h01, 8'h22);
        do_read(8'h01, 0, 2, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            logic [7:0]  b;
            kind = $urandom_range(0, 2);
            b    = 8'($urandom);
            if (kind == 0) begin
                do_write(b, 8'($urandom));
            end else if (kind == 1) begin
                int unsigned bl;
                bl = $urandom_range(1, 6);
                do_read(b, int'($urandom_range(0, 3)), int'(bl), (bl >= 2) && ($urandom_range(0, 3) == 0));
            end else begin
                if (b == WR || b == RD) b = 8'h00;
                do_illegal(b);
            end
        end

        for (int i = 0; i < 16; i++)
            do_read(8'(i), 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
